// File: rtl/ysyx_23060077_ctrl.sv
// Multi-cycle instruction sequencer: owns PC and the latched instruction, steps each
// instruction through FETCH/EXEC/MEM/WB and flags ebreak halts and bus/jump errors.
module ysyx_23060077_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 1023
) (
  input  logic        clock,
  input  logic        reset,
  output logic        ifu_req_o,
  input  logic        ifu_done_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_pc_i,
  output logic        lsu_req_o,
  output logic        lsu_wen_o,
  input  logic        lsu_done_i,
  output logic        rd_wen_o,
  output logic        retire_o,
  output logic [63:0] minstret_o,
  output logic        halt_o,
  output logic        err_o
);

  localparam int              CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO       = CW'(TIMEOUT);
  localparam logic [6:0]      OP_LOAD   = 7'b0000011;
  localparam logic [6:0]      OP_STORE  = 7'b0100011;
  localparam logic [6:0]      OP_BRANCH = 7'b1100011;
  localparam logic [31:0]     EBREAK    = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t        state_q;
  logic [31:0]   pc_q;
  logic [31:0]   inst_q;
  logic [31:0]   npc_q;
  logic [63:0]   minstret_q;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_inc;
  logic [6:0]    opcode;
  logic          is_mem;

  assign opcode   = inst_q[6:0];
  assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign wait_inc = wait_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      minstret_q <= '0;
      wait_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_q  <= '0;
          state_q <= S_FETCH;
        end
        // A done pulse on the last allowed wait cycle still wins over the timeout.
        S_FETCH: begin
          if (ifu_done_i) begin
            inst_q  <= inst_i;
            state_q <= S_EXEC;
          end else if (wait_inc == TMO) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_inc;
          end
        end
        S_EXEC: begin
          if (inst_q == EBREAK) begin
            state_q <= S_HALT;
          end else if (jump_valid_i && (jump_pc_i[1:0] != 2'b00)) begin
            state_q <= S_ERR;
          end else begin
            npc_q   <= jump_valid_i ? jump_pc_i : pc_q + 32'd4;
            wait_q  <= '0;
            state_q <= is_mem ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          if (lsu_done_i) begin
            state_q <= S_WB;
          end else if (wait_inc == TMO) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_inc;
          end
        end
        S_WB: begin
          pc_q       <= npc_q;
          minstret_q <= minstret_q + 64'd1;
          wait_q     <= '0;
          state_q    <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All strobes decode the state register only, so no input reaches an output combinationally.
  assign ifu_req_o  = (state_q == S_FETCH);
  assign lsu_req_o  = (state_q == S_MEM);
  assign lsu_wen_o  = (state_q == S_MEM) && (opcode == OP_STORE);
  assign retire_o   = (state_q == S_WB);
  assign rd_wen_o   = (state_q == S_WB) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
  assign halt_o     = (state_q == S_HALT);
  assign err_o      = (state_q == S_ERR);
  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign minstret_o = minstret_q;

endmodule
